zbin_frame_sequencer: RTL and testbench
=======================================

// Module: zbin_frame_sequencer
// PURPOSE
//  Sequences the photon pulse-counter datapath into 50Hz-synchronous frames of BINS time bins.
//  - Arms on the external 50Hz sync edge.
//  - On each bin tick: writes the live pulse count into ping-pong block RAM and clears the counter.
//  - Hands each completed frame to the readout side with a ready/ack handshake.
//  - Sits between the tick generator, the pulse counter and the frame BRAM.
// PARAMETERS
//  BINS          60         bins per 20ms frame (one per 333us tick)
//  CNT_W         16         pulse-counter / BRAM data width
//  ADDR_W        6          bin address width, must satisfy 2**ADDR_W >= BINS
//  SYNC_TIMEOUT  2500000    clocks with no sync edge before sync-lost (25ms at 100MHz)
// PORTS
//  iClk        in   1        100MHz system clock
//  iRst        in   1        asynchronous, active-high reset
//  iEnable     in   1        level; 0 forces IDLE
//  iSync50Hz   in   1        external 50Hz sync, already synchronised; rising edge detected here
//  iTickBin    in   1        one-cycle bin tick from the tick generator
//  iPulseCnt   in   CNT_W    live pulse-counter value
//  iFrameAck   in   1        one-cycle ack from readout; releases oRdBank
//  oCntClr     out  1        one-cycle clear to the pulse counter
//  oWrEn       out  1        BRAM write strobe
//  oWrBank     out  1        BRAM bank being written
//  oWrAddr     out  ADDR_W   bin index
//  oWrData     out  CNT_W    count written
//  oFrameRdy   out  1        completed frame available in oRdBank
//  oRdBank     out  1        bank holding the completed frame
//  oOverrun    out  1        sticky; a frame was discarded because readout had not acked
//  oSyncErr    out  1        one-cycle pulse; sync edge arrived before BINS bins
//  oSyncLost   out  1        level; no sync edge for SYNC_TIMEOUT clocks
// BEHAVIOUR
//  Reset:
//  - All outputs 0; state IDLE.
//  - Write bank 0; bin index 0; sync_pend 0; watchdog count 0.
//  Outputs:
//  - All outputs are registered.
//  - oWrEn, oCntClr, oWrAddr and oWrData update 1 clk after the iTickBin cycle.
//  - oWrData is iPulseCnt sampled in the tick cycle.
//  States:
//  - IDLE: iEnable=1 -> ARM.
//  - ARM: sync edge or sync_pend -> RUN; bin=0; oCntClr pulses; sync_pend cleared.
//  - RUN, iTickBin: write {oWrBank, bin}, pulse oCntClr, bin++.
//    Tick on bin BINS-1 -> DONE.
//  - RUN, sync edge on a non-final bin:
//    - Frame aborted; oSyncErr pulses.
//    - bin=0; oCntClr pulses; stay in RUN.
//    - A coincident tick is dropped.
//  - Sync edge coincident with the final tick, or sync edge while in DONE: sets sync_pend.
//    ARM then consumes sync_pend with zero wait.
//  - DONE (1 clk) -> ARM:
//    - If oFrameRdy=0, or iFrameAck is high this cycle: oRdBank<=oWrBank; oWrBank flips; oFrameRdy<=1.
//    - Otherwise: no flip; frame discarded; oOverrun<=1.
//  Handshake:
//  - iFrameAck clears oFrameRdy and oOverrun.
//  - Ack with oFrameRdy=0 is ignored.
//  - Ack in the same cycle as DONE: the ack is applied first.
//  Watchdog:
//  - Counts in ARM and RUN; restarts on every sync edge.
//  - Reaching SYNC_TIMEOUT:
//    - oSyncLost=1.
//    - State -> ARM; the frame in progress is discarded.
//  - The next sync edge clears oSyncLost.
//  iEnable=0 in any state:
//  - Next clk state=IDLE; the partial frame is discarded; no write.
//  - oFrameRdy, oRdBank and oOverrun are held.
//  iRst mid-frame: immediate return to reset values; no further write strobes.
//  Widths: bin index is ADDR_W bits, compared against BINS-1 and never wraps past it.
// STRUCTURE
//  Shared package zpd_pkg:
//  - State encoding IDLE/ARM/RUN/DONE.
//  - BINS, CNT_W, ADDR_W defaults.
//  Sub-module zsync_watchdog:
//  - Sync rising-edge detect and timeout counter.
//  - Outputs sync_edge and timeout.
// TESTING
//  1. Enable, sync edge, 60 ticks at 33333 clk:
//     - 60 writes, addr 0..59, bank 0, data = injected counts.
//     - oFrameRdy=1, oRdBank=0, oWrBank=1.
//  2. Frame 1 not acked, frame 2 completes:
//     - oOverrun=1; oRdBank stays 0; oWrBank stays 1.
//     - Ack clears both flags.
//  3. Sync edge after 30 ticks: oSyncErr 1 clk; next write is addr 0.
//  4. Sync coincident with tick 59: frame completes; next frame starts with no ARM wait.
//  5. Hold sync low 2.5M clk: oSyncLost=1, state ARM; next sync edge clears it.
//  6. iEnable=0 at bin 10: no further writes; IDLE; re-enable re-arms at bin 0.

Source files
------------

// File: rtl/zpd_pkg.sv
// Shared definitions for the z-bin frame sequencer: state encoding and default geometry.
package zpd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int BINS_DEF         = 60;
  localparam int CNT_W_DEF        = 16;
  localparam int ADDR_W_DEF       = 6;
  localparam int SYNC_TIMEOUT_DEF = 2500000;

endpackage

// File: rtl/zbin_frame_sequencer_if.sv
// Bus between the frame sequencer and its neighbours (tick gen, pulse counter, BRAM, readout).
interface zbin_frame_sequencer_if #(
  parameter int CNT_W  = zpd_pkg::CNT_W_DEF,
  parameter int ADDR_W = zpd_pkg::ADDR_W_DEF
) ();

  logic              iEnable;
  logic              iSync50Hz;
  logic              iTickBin;
  logic [CNT_W-1:0]  iPulseCnt;
  logic              iFrameAck;

  logic              oCntClr;
  logic              oWrEn;
  logic              oWrBank;
  logic [ADDR_W-1:0] oWrAddr;
  logic [CNT_W-1:0]  oWrData;
  logic              oFrameRdy;
  logic              oRdBank;
  logic              oOverrun;
  logic              oSyncErr;
  logic              oSyncLost;
  zpd_pkg::state_t   dbgState;

  // Readout handshake: oFrameRdy is the valid flag for the frame in oRdBank; iFrameAck
  // is a one-cycle ready/accept. A frame is consumed in any cycle where both are high;
  // an ack with oFrameRdy low is ignored.
  modport master (
    input  iEnable, iSync50Hz, iTickBin, iPulseCnt, iFrameAck,
    output oCntClr, oWrEn, oWrBank, oWrAddr, oWrData,
    output oFrameRdy, oRdBank, oOverrun, oSyncErr, oSyncLost, dbgState
  );

  modport slave (
    output iEnable, iSync50Hz, iTickBin, iPulseCnt, iFrameAck,
    input  oCntClr, oWrEn, oWrBank, oWrAddr, oWrData,
    input  oFrameRdy, oRdBank, oOverrun, oSyncErr, oSyncLost, dbgState
  );

endinterface

// File: rtl/zsync_watchdog.sv
// Rising-edge detect on the 50Hz sync and a clock counter that flags a missing sync.
module zsync_watchdog #(
  parameter int SYNC_TIMEOUT = zpd_pkg::SYNC_TIMEOUT_DEF
) (
  input  logic iClk,
  input  logic iRst,
  input  logic iSync,
  input  logic iCountEn,
  input  logic iClear,
  output logic oSyncEdge,
  output logic oTimeout
);

  localparam int CW = $clog2(SYNC_TIMEOUT + 1);

  logic          syncQ;
  logic [CW-1:0] cnt;

  assign oSyncEdge = iSync & ~syncQ;
  // A sync edge in the same cycle wins over an expiring count.
  assign oTimeout  = iCountEn & ~oSyncEdge & (cnt == CW'(SYNC_TIMEOUT - 1));

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      syncQ <= 1'b0;
      cnt   <= '0;
    end else begin
      syncQ <= iSync;
      if (iClear || oSyncEdge || oTimeout) cnt <= '0;
      else if (iCountEn)                  cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/zbin_frame_sequencer.sv
// Frames the pulse-counter datapath into sync-aligned frames of BINS bins, writing each
// bin into ping-pong BRAM and handing completed banks to readout.
module zbin_frame_sequencer
  import zpd_pkg::*;
#(
  parameter int BINS         = BINS_DEF,
  parameter int CNT_W        = CNT_W_DEF,
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int SYNC_TIMEOUT = SYNC_TIMEOUT_DEF
) (
  input logic iClk,
  input logic iRst,
  zbin_frame_sequencer_if.master bus
);

  state_t            state, stateNxt;
  logic [ADDR_W-1:0] bin, binNxt;
  logic              wrBank, wrBankNxt, syncPend, syncPendNxt;
  logic              cntClrQ, cntClrNxt, wrEnQ, wrEnNxt, syncErrQ, syncErrNxt;
  logic              frameRdyQ, frameRdyNxt, rdBankQ, rdBankNxt;
  logic              overrunQ, overrunNxt, syncLostQ, syncLostNxt;
  logic [ADDR_W-1:0] wrAddrQ, wrAddrNxt;
  logic [CNT_W-1:0]  wrDataQ, wrDataNxt;
  logic              en, tick, ack, syncEdge, timeout, lastBin;

  assign en      = bus.iEnable;
  assign tick    = bus.iTickBin;
  assign ack     = bus.iFrameAck;
  assign lastBin = (bin == ADDR_W'(BINS - 1));

  zsync_watchdog #(.SYNC_TIMEOUT(SYNC_TIMEOUT)) uWatchdog (
    .iClk      (iClk),
    .iRst      (iRst),
    .iSync     (bus.iSync50Hz),
    .iCountEn  ((state == ARM) || (state == RUN)),
    .iClear    (state == IDLE),
    .oSyncEdge (syncEdge),
    .oTimeout  (timeout)
  );

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state     <= IDLE;
      bin       <= '0;
      wrBank    <= 1'b0;
      syncPend  <= 1'b0;
      cntClrQ   <= 1'b0;
      wrEnQ     <= 1'b0;
      wrAddrQ   <= '0;
      wrDataQ   <= '0;
      frameRdyQ <= 1'b0;
      rdBankQ   <= 1'b0;
      overrunQ  <= 1'b0;
      syncErrQ  <= 1'b0;
      syncLostQ <= 1'b0;
    end else begin
      state     <= stateNxt;
      bin       <= binNxt;
      wrBank    <= wrBankNxt;
      syncPend  <= syncPendNxt;
      cntClrQ   <= cntClrNxt;
      wrEnQ     <= wrEnNxt;
      wrAddrQ   <= wrAddrNxt;
      wrDataQ   <= wrDataNxt;
      frameRdyQ <= frameRdyNxt;
      rdBankQ   <= rdBankNxt;
      overrunQ  <= overrunNxt;
      syncErrQ  <= syncErrNxt;
      syncLostQ <= syncLostNxt;
    end
  end

  always_comb begin
    stateNxt = state;
    unique case (state)
      IDLE:    if (en) stateNxt = ARM;
      ARM:     if (syncEdge || syncPend) stateNxt = RUN;
      RUN:     if (tick && lastBin) stateNxt = DONE;
      DONE:    stateNxt = ARM;
      default: stateNxt = IDLE;
    endcase
    if (timeout) stateNxt = ARM;
    if (!en)     stateNxt = IDLE;
  end

  always_comb begin
    binNxt      = bin;
    wrBankNxt   = wrBank;
    syncPendNxt = syncPend;
    cntClrNxt   = 1'b0;
    wrEnNxt     = 1'b0;
    syncErrNxt  = 1'b0;
    wrAddrNxt   = wrAddrQ;
    wrDataNxt   = wrDataQ;
    frameRdyNxt = frameRdyQ;
    rdBankNxt   = rdBankQ;
    overrunNxt  = overrunQ;
    syncLostNxt = syncLostQ;

    // The ack is applied before any DONE hand-over in the same cycle.
    if (ack && frameRdyQ) begin
      frameRdyNxt = 1'b0;
      overrunNxt  = 1'b0;
    end
    if (syncEdge) syncLostNxt = 1'b0;

    if (!en) begin
      binNxt      = '0;
      syncPendNxt = 1'b0;
    end else if (timeout) begin
      syncLostNxt = 1'b1;
      binNxt      = '0;
      syncPendNxt = 1'b0;
    end else begin
      unique case (state)
        ARM: if (syncEdge || syncPend) begin
          binNxt      = '0;
          cntClrNxt   = 1'b1;
          syncPendNxt = 1'b0;
        end
        RUN: begin
          if (tick && (lastBin || !syncEdge)) begin
            wrEnNxt   = 1'b1;
            cntClrNxt = 1'b1;
            wrAddrNxt = bin;
            wrDataNxt = bus.iPulseCnt;
            binNxt    = lastBin ? '0 : bin + ADDR_W'(1);
            if (lastBin && syncEdge) syncPendNxt = 1'b1;
          end else if (syncEdge) begin
            syncErrNxt = 1'b1;
            binNxt     = '0;
            cntClrNxt  = 1'b1;
          end
        end
        DONE: begin
          if (syncEdge) syncPendNxt = 1'b1;
          if (!frameRdyQ || ack) begin
            rdBankNxt   = wrBank;
            wrBankNxt   = ~wrBank;
            frameRdyNxt = 1'b1;
          end else begin
            overrunNxt = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.oCntClr   = cntClrQ;
  assign bus.oWrEn     = wrEnQ;
  assign bus.oWrBank   = wrBank;
  assign bus.oWrAddr   = wrAddrQ;
  assign bus.oWrData   = wrDataQ;
  assign bus.oFrameRdy = frameRdyQ;
  assign bus.oRdBank   = rdBankQ;
  assign bus.oOverrun  = overrunQ;
  assign bus.oSyncErr  = syncErrQ;
  assign bus.oSyncLost = syncLostQ;
  assign bus.dbgState  = state;

endmodule

// File: tb/tb_zbin_frame_sequencer.sv
// Directed bench for zbin_frame_sequencer: frames, overrun, sync abort/coincidence, sync loss, disable, reset.
module tb_zbin_frame_sequencer;
  import zpd_pkg::*;

  localparam int BINS         = 60;
  localparam int CNT_W        = 16;
  localparam int ADDR_W       = 6;
  localparam int SYNC_TIMEOUT = 3000;
  localparam int TICK_GAP     = 20;
  localparam int EW           = 1 + ADDR_W + CNT_W;

  logic iClk = 1'b0;
  logic iRst;

  zbin_frame_sequencer_if #(.CNT_W(CNT_W), .ADDR_W(ADDR_W)) bus ();

  zbin_frame_sequencer #(
    .BINS(BINS), .CNT_W(CNT_W), .ADDR_W(ADDR_W), .SYNC_TIMEOUT(SYNC_TIMEOUT)
  ) dut (
    .iClk (iClk),
    .iRst (iRst),
    .bus  (bus)
  );

  // Clock and global time bound
  always #5 iClk = ~iClk;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish, expected finish before 2ms");
    $fatal(1);
  end

  int nChecks = 0;
  int nFails  = 0;
  int nWrites = 0;
  logic [EW-1:0] expQ[$];

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every BRAM write must match the head of the expected queue
  always @(negedge iClk) begin
    if (bus.oWrEn === 1'b1) begin
      nWrites++;
      checkVal("wr_cntclr", bus.oCntClr, 1);
      if (expQ.size() == 0) checkVal("wr_extra", expQ.size(), 1);
      else checkVal("wr_data", {bus.oWrBank, bus.oWrAddr, bus.oWrData}, expQ.pop_front());
    end
  end

  // Driver tasks: inputs change 1ns after a rising edge, outputs are read there too
  task automatic step();
    @(posedge iClk);
    #1;
  endtask

  task automatic doTick(input logic [CNT_W-1:0] val, input bit expWr, input logic bank, input int addr);
    bus.iTickBin  = 1'b1;
    bus.iPulseCnt = val;
    if (expWr) expQ.push_back({bank, ADDR_W'(addr), val});
    step();
    bus.iTickBin = 1'b0;
    repeat (TICK_GAP - 1) step();
  endtask

  task automatic runTicks(input int first, input int n, input logic bank, input logic [CNT_W-1:0] base);
    for (int i = 0; i < n; i++)
      doTick(base + CNT_W'((first + i) * 37), 1'b1, bank, first + i);
  endtask

  task automatic syncRise();
    bus.iSync50Hz = 1'b1;
    step();
    bus.iSync50Hz = 1'b0;
  endtask

  task automatic ackFrame();
    bus.iFrameAck = 1'b1;
    step();
    bus.iFrameAck = 1'b0;
  endtask

  task automatic checkResetOuts(input string tag);
    checkVal(tag, {bus.oCntClr, bus.oWrEn, bus.oWrBank, bus.oWrAddr, bus.oWrData,
                   bus.oFrameRdy, bus.oRdBank, bus.oOverrun, bus.oSyncErr, bus.oSyncLost}, 0);
    checkVal({tag, "_state"}, bus.dbgState, IDLE);
  endtask

  initial begin
    iRst          = 1'b1;
    bus.iEnable   = 1'b0;
    bus.iSync50Hz = 1'b0;
    bus.iTickBin  = 1'b0;
    bus.iPulseCnt = '0;
    bus.iFrameAck = 1'b0;
    repeat (3) step();
    checkResetOuts("reset");
    iRst = 1'b0;
    step();
    checkVal("idle_disabled", bus.dbgState, IDLE);
    bus.iEnable = 1'b1;
    step();
    checkVal("arm_on_enable", bus.dbgState, ARM);

    // 1: full frame into bank 0
    syncRise();
    checkVal("t1_run", bus.dbgState, RUN);
    checkVal("t1_cntclr", bus.oCntClr, 1);
    runTicks(0, BINS, 1'b0, 16'h1000);
    checkVal("t1_rdy", bus.oFrameRdy, 1);
    checkVal("t1_rdbank", bus.oRdBank, 0);
    checkVal("t1_wrbank", bus.oWrBank, 1);
    checkVal("t1_arm", bus.dbgState, ARM);

    // 2: second frame without ack is discarded
    syncRise();
    runTicks(0, BINS, 1'b1, 16'h2000);
    checkVal("t2_overrun", bus.oOverrun, 1);
    checkVal("t2_rdy", bus.oFrameRdy, 1);
    checkVal("t2_rdbank", bus.oRdBank, 0);
    checkVal("t2_wrbank", bus.oWrBank, 1);
    ackFrame();
    checkVal("t2_ack_rdy", bus.oFrameRdy, 0);
    checkVal("t2_ack_ovr", bus.oOverrun, 0);

    // 3: sync edge after 30 bins aborts the frame
    syncRise();
    runTicks(0, 30, 1'b1, 16'h3000);
    syncRise();
    checkVal("t3_syncerr", bus.oSyncErr, 1);
    checkVal("t3_cntclr", bus.oCntClr, 1);
    checkVal("t3_run", bus.dbgState, RUN);
    step();
    checkVal("t3_syncerr_pulse", bus.oSyncErr, 0);
    runTicks(0, BINS, 1'b1, 16'h3800);
    checkVal("t3_rdy", bus.oFrameRdy, 1);
    checkVal("t3_rdbank", bus.oRdBank, 1);
    checkVal("t3_wrbank", bus.oWrBank, 0);
    ackFrame();
    checkVal("t3_ack_rdy", bus.oFrameRdy, 0);

    // 4: sync coincident with the final tick
    syncRise();
    runTicks(0, BINS - 1, 1'b0, 16'h4000);
    bus.iTickBin  = 1'b1;
    bus.iPulseCnt = 16'h4ABC;
    bus.iSync50Hz = 1'b1;
    expQ.push_back({1'b0, 6'd59, 16'h4ABC});
    step();
    bus.iTickBin  = 1'b0;
    bus.iSync50Hz = 1'b0;
    checkVal("t4_done", bus.dbgState, DONE);
    checkVal("t4_noerr", bus.oSyncErr, 0);
    step();
    checkVal("t4_arm", bus.dbgState, ARM);
    checkVal("t4_rdy", bus.oFrameRdy, 1);
    checkVal("t4_rdbank", bus.oRdBank, 0);
    checkVal("t4_wrbank", bus.oWrBank, 1);
    step();
    checkVal("t4_run_nowait", bus.dbgState, RUN);
    checkVal("t4_cntclr", bus.oCntClr, 1);

    // 5: sync held low until the watchdog fires
    ackFrame();
    repeat (2490) step();
    checkVal("t5_not_yet_lost", bus.oSyncLost, 0);
    for (int i = 0; i < 1000 && bus.oSyncLost !== 1'b1; i++) step();
    checkVal("t5_lost", bus.oSyncLost, 1);
    checkVal("t5_arm", bus.dbgState, ARM);
    syncRise();
    checkVal("t5_lost_clr", bus.oSyncLost, 0);
    checkVal("t5_run", bus.dbgState, RUN);

    // 6: disable at bin 10, then re-enable
    runTicks(0, 10, 1'b1, 16'h6000);
    bus.iEnable = 1'b0;
    step();
    checkVal("t6_idle", bus.dbgState, IDLE);
    doTick(16'h7777, 1'b0, 1'b0, 0);
    doTick(16'h7778, 1'b0, 1'b0, 0);
    checkVal("t6_still_idle", bus.dbgState, IDLE);
    checkVal("t6_wrbank_held", bus.oWrBank, 1);
    bus.iEnable = 1'b1;
    step();
    checkVal("t6_rearm", bus.dbgState, ARM);
    syncRise();
    checkVal("t6_run", bus.dbgState, RUN);
    doTick(16'h6ABC, 1'b1, 1'b1, 0);

    // 7: asynchronous reset mid-frame
    runTicks(1, 5, 1'b1, 16'h7000);
    iRst = 1'b1;
    #1;
    checkResetOuts("t7_async_rst");
    doTick(16'h7F00, 1'b0, 1'b0, 0);
    checkResetOuts("t7_held_rst");
    iRst = 1'b0;
    step();

    checkVal("expq_empty", expQ.size(), 0);
    checkVal("write_count", nWrites, 286);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
